// File: rtl/dip_defs_pkg.sv
// rtl/dip_defs_pkg.sv - shared defaults for the trainer DIP switch debouncer
package dip_defs_pkg;

  localparam int DIP_WIDTH_DEF           = 8;
  localparam int DIP_DEBOUNCE_CYCLES_DEF = 16;
  localparam int DIP_DEBOUNCE_CYCLES_SIM = 4;

  function automatic int dip_cnt_w(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/dip_debounce_bit.sv
// rtl/dip_debounce_bit.sv - synchronizer, stability counter and stable register for one switch line
module dip_debounce_bit
  import dip_defs_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DIP_DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = dip_cnt_w(DEBOUNCE_CYCLES)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_stable,
  output logic o_flip
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differ;

  assign w_differ = (r_s2 != r_stable);
  // Flip is the toggle decision for this edge, so the event logic can see the new level in the same cycle.
  assign o_flip   = w_differ && (r_cnt == CNT_MAX);
  assign o_stable = r_stable;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (o_flip) begin
        r_stable <= ~r_stable;
        r_cnt    <= '0;
      end else if (w_differ) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/trainer_dip_debouncer.sv
// rtl/trainer_dip_debouncer.sv - debounced DIP switch bank with valid/ready change events
module trainer_dip_debouncer
  import dip_defs_pkg::*;
#(
  parameter int WIDTH           = DIP_WIDTH_DEF,
  parameter int DEBOUNCE_CYCLES = DIP_DEBOUNCE_CYCLES_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_dip_raw,
  output logic [WIDTH-1:0] o_dip_stable,
  output logic             o_change_valid,
  input  logic             i_change_ready,
  output logic [WIDTH-1:0] o_change_value,
  output logic [WIDTH-1:0] o_change_mask
);

  localparam int CNT_W = dip_cnt_w(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_flip;
  logic [WIDTH-1:0] w_stable_next;
  logic             w_accept;
  logic             r_valid;
  logic [WIDTH-1:0] r_value;
  logic [WIDTH-1:0] r_mask;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    dip_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_bit (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_raw    (i_dip_raw[gi]),
      .o_stable (w_stable[gi]),
      .o_flip   (w_flip[gi])
    );
  end

  assign w_stable_next = w_stable ^ w_flip;
  assign w_accept      = r_valid && i_change_ready;

  // A new flip on the accept edge starts a fresh event; without acceptance it folds into the pending one.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_value <= '0;
      r_mask  <= '0;
    end else if (w_flip != '0) begin
      r_valid <= 1'b1;
      r_value <= w_stable_next;
      r_mask  <= (!r_valid || w_accept) ? w_flip : (r_mask | w_flip);
    end else if (w_accept) begin
      r_valid <= 1'b0;
      r_mask  <= '0;
    end
  end

  assign o_dip_stable   = w_stable;
  assign o_change_valid = r_valid;
  assign o_change_value = r_value;
  assign o_change_mask  = r_mask;

endmodule

// File: tb/tb_trainer_dip_debouncer.sv
// tb/tb_trainer_dip_debouncer.sv - directed scoreboard bench for trainer_dip_debouncer
module tb_trainer_dip_debouncer
  import dip_defs_pkg::*;
;

  logic       clk;
  logic       rst_n;
  logic [7:0] dip_raw;
  logic [7:0] dip_stable;
  logic       change_valid;
  logic       change_ready;
  logic [7:0] change_value;
  logic [7:0] change_mask;

  int n_checks = 0;
  int n_err    = 0;
  logic [15:0] sb[$];

  trainer_dip_debouncer #(
    .WIDTH           (8),
    .DEBOUNCE_CYCLES (DIP_DEBOUNCE_CYCLES_SIM)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_dip_raw      (dip_raw),
    .o_dip_stable   (dip_stable),
    .o_change_valid (change_valid),
    .i_change_ready (change_ready),
    .o_change_value (change_value),
    .o_change_mask  (change_mask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_stable"}, dip_stable, 8'h00);
    chk({tag, "_valid"}, {7'd0, change_valid}, 8'h00);
    chk({tag, "_value"}, change_value, 8'h00);
    chk({tag, "_mask"}, change_mask, 8'h00);
  endtask

  // Accepted events are popped here, one edge ahead of the handshake edge.
  always @(negedge clk) begin
    if (change_valid && change_ready) begin
      logic [15:0] exp;
      n_checks++;
      assert (sb.size() > 0) else begin
        n_err++;
        $error("FAIL evt_unexpected observed=%h/%h expected=none", change_value, change_mask);
      end
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        chk("evt_value", change_value, exp[15:8]);
        chk("evt_mask", change_mask, exp[7:0]);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    dip_raw = 8'hFF;
    change_ready = 1'b1;

    // Reset flush
    tick(3);
    chk_idle("rst");
    rst_n = 1'b1;
    sb.push_back({8'hFF, 8'hFF});
    tick(5);
    chk("rst_pre_stable", dip_stable, 8'h00);
    chk("rst_pre_valid", {7'd0, change_valid}, 8'h00);
    tick(1);
    chk("rst_stable", dip_stable, 8'hFF);
    chk("rst_valid", {7'd0, change_valid}, 8'h01);
    chk("rst_value", change_value, 8'hFF);
    chk("rst_mask", change_mask, 8'hFF);
    tick(1);
    chk("rst_drop_valid", {7'd0, change_valid}, 8'h00);
    chk("rst_drop_mask", change_mask, 8'h00);
    chk("rst_hold_value", change_value, 8'hFF);

    // Clean change: FF -> 00 -> 0F
    dip_raw = 8'h00;
    sb.push_back({8'h00, 8'hFF});
    tick(6);
    chk("clr_stable", dip_stable, 8'h00);
    tick(1);
    dip_raw = 8'h0F;
    sb.push_back({8'h0F, 8'h0F});
    tick(5);
    chk("cc_pre_stable", dip_stable, 8'h00);
    tick(1);
    chk("cc_stable", dip_stable, 8'h0F);
    chk("cc_valid", {7'd0, change_valid}, 8'h01);
    chk("cc_value", change_value, 8'h0F);
    chk("cc_mask", change_mask, 8'h0F);
    tick(1);
    chk("cc_drop_valid", {7'd0, change_valid}, 8'h00);

    // Glitch reject: three-cycle pulse on bit 7
    dip_raw = 8'h8F;
    tick(3);
    dip_raw = 8'h0F;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("gl_stable", dip_stable, 8'h0F);
      chk("gl_valid", {7'd0, change_valid}, 8'h00);
    end

    // Coalesce under backpressure
    change_ready = 1'b0;
    dip_raw = 8'h8F;
    tick(6);
    chk("co_first_valid", {7'd0, change_valid}, 8'h01);
    chk("co_first_value", change_value, 8'h8F);
    chk("co_first_mask", change_mask, 8'h80);
    dip_raw = 8'h8E;
    sb.push_back({8'h8E, 8'h81});
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("co_hold_valid", {7'd0, change_valid}, 8'h01);
    end
    chk("co_value", change_value, 8'h8E);
    chk("co_mask", change_mask, 8'h81);
    change_ready = 1'b1;
    tick(1);
    change_ready = 1'b0;
    chk("co_acc_valid", {7'd0, change_valid}, 8'h00);
    chk("co_acc_mask", change_mask, 8'h00);
    chk("co_acc_value", change_value, 8'h8E);

    // Accept on the same edge as a new flip
    dip_raw = 8'h8C;
    sb.push_back({8'h8C, 8'h02});
    tick(6);
    chk("col_a_value", change_value, 8'h8C);
    chk("col_a_mask", change_mask, 8'h02);
    dip_raw = 8'h8D;
    sb.push_back({8'h8D, 8'h01});
    tick(5);
    change_ready = 1'b1;
    tick(1);
    chk("col_stable", dip_stable, 8'h8D);
    chk("col_valid", {7'd0, change_valid}, 8'h01);
    chk("col_value", change_value, 8'h8D);
    chk("col_mask", change_mask, 8'h01);
    tick(1);
    chk("col_drop_valid", {7'd0, change_valid}, 8'h00);

    // Reset mid-count
    dip_raw = 8'h0D;
    tick(5);
    rst_n = 1'b0;
    tick(2);
    chk_idle("rmc");
    rst_n = 1'b1;
    sb.push_back({8'h0D, 8'h0D});
    tick(5);
    chk("rmc_pre_stable", dip_stable, 8'h00);
    chk("rmc_pre_valid", {7'd0, change_valid}, 8'h00);
    tick(1);
    chk("rmc_stable", dip_stable, 8'h0D);
    chk("rmc_valid", {7'd0, change_valid}, 8'h01);
    chk("rmc_value", change_value, 8'h0D);
    chk("rmc_mask", change_mask, 8'h0D);
    tick(1);
    chk("rmc_drop_valid", {7'd0, change_valid}, 8'h00);

    tick(2);
    chk("sb_empty", 8'(sb.size()), 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/trainer_dip_debouncer.md
# trainer_dip_debouncer

Input-side conditioner for the trainer board DIP switch bank. Synchronizes each raw switch line into the `clk` domain and filters contact bounce with a per-bit stability counter. Presents a clean `dip_stable` vector and a valid/ready change-event port, so downstream logic (LED mapper, register file) reacts to debounced edges instead of polling.

## Interface
- `WIDTH`, 8: number of switch lines.
- `DEBOUNCE_CYCLES`, 16: consecutive synchronized cycles a new level must persist before it is accepted; minimum 2.
- `CNT_W`, `$clog2(DEBOUNCE_CYCLES)`: per-bit counter width (derived, not overridden).

Ports:
- `clk` in 1: single system clock. One clock; reset is synchronous and active-low.
- `rst_n` in 1: synchronous, active-low reset.
- `dip_raw` in WIDTH: asynchronous switch inputs (trainer_dip).
- `dip_stable` out WIDTH: debounced switch state.
- `change_valid` out 1: a change event is pending.
- `change_ready` in 1: consumer accepts the event.
- `change_value` out WIDTH: `dip_stable` value at the most recent change.
- `change_mask` out WIDTH: bits that flipped since the last accepted event.

## Operation
- Per bit, a 2-FF synchronizer (`s1`, `s2`) is followed by a counter `cnt` and a `stable` register.
- Each edge with `s2 != stable`:
  - if `cnt == DEBOUNCE_CYCLES-1`, `stable` toggles and `cnt` clears;
  - else `cnt` increments.
- Each edge with `s2 == stable`: `cnt` clears. A glitch shorter than `DEBOUNCE_CYCLES` never reaches `dip_stable`.
- `flip[i]` is high on the edge where bit i toggles.
- `flip != 0` on the edge where event logic runs:
  - if no event is pending, or one is pending and accepted on that edge, load `change_value` with the new stable vector and `change_mask` with `flip`, and set `change_valid`.
  - if an event is pending and not accepted, coalesce: `change_value` takes the new stable vector and `change_mask` ORs in `flip`. `change_valid` stays 1.
- `flip == 0` and `change_valid && change_ready`: clear `change_valid`. `change_mask` clears to 0. `change_value` holds.
- A bit that flips twice while the event is unaccepted keeps its mask bit set; `change_value` shows its current level.
- Reset: all synchronizers, counters, `dip_stable`, `change_valid`, `change_value`, and `change_mask` clear to 0.
- Released switches reading 1 after reset therefore generate a normal debounced event.
- Reset asserted mid-count discards the count.

## Timing
- Raw level change sampled at edge k:
  - `s2` updates at edge k+1;
  - `dip_stable` updates at edge k+DEBOUNCE_CYCLES+1;
  - total latency is DEBOUNCE_CYCLES+2 edges.
- `change_valid`, `change_value`, and `change_mask` update on the same edge as `dip_stable`.
- Handshake completes on any edge with `change_valid && change_ready`.
- `change_valid` never drops without acceptance, except on reset.
- `change_ready` may be held high permanently. Each event is then valid for exactly one cycle, unless a new flip lands on the accept edge.
- Outputs are all registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package or header `dip_defs`: default `WIDTH` (8) and default `DEBOUNCE_CYCLES`. The simulation override value 4 lives here as well.
- Sub-module `dip_debounce_bit`: synchronizer, counter, and stable register for one line.
  - Outputs `stable` and `flip`.
  - Instantiated WIDTH times via generate.
- The top level holds the event register and handshake only.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`.

- **Reset flush.** Hold `rst_n=0` 3 cycles with `dip_raw=8'hFF`, then release with `change_ready=1`.
  - During reset, all outputs are 0.
  - `dip_stable=8'hFF` and `change_valid=1` with value FF, mask FF appear 6 edges after release. Valid drops next cycle.
- **Clean change.** `dip_raw` goes 00 → 0F, `change_ready=1`.
  - After 6 edges: `dip_stable=0F`, with a one-cycle event of value 0F, mask 0F.
- **Glitch reject.** Pulse bit 7 high for 3 cycles, then return low.
  - `dip_stable` stays 0F and `change_valid` stays 0 throughout.
- **Coalesce under backpressure.** With `change_ready=0`, change 0F → 8F; once valid, change 8F → 8E.
  - `change_valid` stays 1, `change_value=8E`, `change_mask=81`.
  - Raising `change_ready` for 1 cycle clears valid and the mask.
- **Accept/new-flip collision.** Assert `change_ready` on the exact edge bit 0 flips again.
  - Valid stays 1; mask equals the new flip only (01). The old mask is gone.
- **Reset mid-count.** Change `dip_raw` and assert `rst_n=0` after 3 counting cycles, then release.
  - Outputs read 0 during reset.
  - After release, a fresh 6-edge latency applies before `dip_stable` reflects `dip_raw`.
